// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Results are held on bcd_out/neg_out between out_valid pulses so a display never sees partial values.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int BCD_W  = 4 * DIGITS;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_fit();
        logic [127:0] p10;
        logic [127:0] lim;
        p10 = 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p10 = p10 * 128'd10;
        end
        lim = 128'd1 << WIDTH;
        return p10 >= lim;
    endfunction

    localparam bit DIGITS_OK = digits_fit();

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH must be >= 2");
        end
        if (!DIGITS_OK) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]   acc_reg, acc_next;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sign_reg, sign_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic               neg_reg, neg_next;
    logic               out_valid_reg, out_valid_next;

    logic               in_neg;
    logic [WIDTH-1:0]   in_mag;

    // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    assign in_neg = (SIGNED != 0) && bin_in[WIDTH-1];
    assign in_mag = in_neg ? ({WIDTH{1'b0}} - bin_in) : bin_in;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5)
                                        ? acc_reg[4*gi +: 4] + 4'd3
                                        : acc_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bin_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            bcd_reg       <= '0;
            neg_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bin_reg       <= bin_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            sign_reg      <= sign_next;
            bcd_reg       <= bcd_next;
            neg_reg       <= neg_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bin_next       = bin_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        sign_next      = sign_reg;
        bcd_next       = bcd_reg;
        neg_next       = neg_reg;
        out_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    bin_next   = in_mag;
                    sign_next  = in_neg;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Correct digits first, then shift the binary MSB into the accumulator.
                acc_next = {acc_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
                bin_next = bin_reg << 1;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next       = acc_reg;
                neg_next       = sign_reg;
                out_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign bcd_out   = bcd_reg;
    assign neg_out   = neg_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an unsigned and a signed instance driven in lockstep,
// checked against hand-computed vectors, corner-case sequences and a decimal reference.
module tb_bin_to_bcd_seq;

    localparam int W   = 16;
    localparam int D   = 5;
    localparam int LAT = W + 1;   // edges after the accept edge until out_valid is seen

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  bin_in;
    logic          in_ready_u, out_valid_u, neg_u;
    logic          in_ready_s, out_valid_s, neg_s;
    logic [4*D-1:0] bcd_u, bcd_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .bin_in(bin_in), .out_valid(out_valid_u), .bcd_out(bcd_u), .neg_out(neg_u)
    );

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .bin_in(bin_in), .out_valid(out_valid_s), .bcd_out(bcd_s), .neg_out(neg_s)
    );

    typedef struct {
        logic [W-1:0]   bin;
        logic [4*D-1:0] u_bcd;
        logic [4*D-1:0] s_bcd;
        logic           s_neg;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned    t;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(in_ready_u && in_ready_s) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: in_ready never rose within 50 cycles");
        end
    endtask

    // One full conversion on both instances; returns both results and checks timing.
    task automatic convert(input logic [W-1:0] v, output logic [4*D-1:0] bu,
                           output logic [4*D-1:0] bs, output logic ns);
        int  k;
        bit  ready_low;
        wait_idle();
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = '0;
        k = 0;
        ready_low = 1'b1;
        while (!out_valid_u && k < 40) begin
            if (in_ready_u) ready_low = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        bu = bcd_u;
        bs = bcd_s;
        ns = neg_s;
        check("latency", 32'(k), 32'(LAT));
        check("busy_in_ready", {31'd0, ready_low}, 32'd1);
        check("ready_at_out", {31'd0, in_ready_u}, 32'd1);
        check("signed_in_step", {31'd0, out_valid_s}, 32'd1);
        check("neg_unsigned", {31'd0, neg_u}, 32'd0);
        @(posedge clk); #1;
        check("single_pulse", {30'd0, out_valid_u, out_valid_s}, 32'd0);
    endtask

    initial begin
        logic [4*D-1:0] bu, bs, r0, r1;
        logic           ns;
        int             t0, t1, p;

        vecs[0]  = '{16'h0000, 20'h00000, 20'h00000, 1'b0};
        vecs[1]  = '{16'hFFFF, 20'h65535, 20'h00001, 1'b1};
        vecs[2]  = '{16'd1234, 20'h01234, 20'h01234, 1'b0};
        vecs[3]  = '{16'h8000, 20'h32768, 20'h32768, 1'b1};
        vecs[4]  = '{16'h7FFF, 20'h32767, 20'h32767, 1'b0};
        vecs[5]  = '{16'd9999, 20'h09999, 20'h09999, 1'b0};
        vecs[6]  = '{16'd4321, 20'h04321, 20'h04321, 1'b0};
        vecs[7]  = '{16'd10000, 20'h10000, 20'h10000, 1'b0};
        vecs[8]  = '{16'hFF85, 20'h65413, 20'h00123, 1'b1};
        vecs[9]  = '{16'd1, 20'h00001, 20'h00001, 1'b0};
        vecs[10] = '{16'hC000, 20'h49152, 20'h16384, 1'b1};
        vecs[11] = '{16'd5, 20'h00005, 20'h00005, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready_u}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
        check("rst_bcd", 32'(bcd_u), 32'd0);
        check("rst_neg", {31'd0, neg_s}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, bu, bs, ns);
            $display("vec %0d: bin=%h u=%h s=%h neg=%0b", i, vecs[i].bin, bu, bs, ns);
            check("vec_u_bcd", 32'(bu), 32'(vecs[i].u_bcd));
            check("vec_s_bcd", 32'(bs), 32'(vecs[i].s_bcd));
            check("vec_s_neg", {31'd0, ns}, {31'd0, vecs[i].s_neg});
        end

        // in_valid held high: value changes mid-conversion are ignored; next accept in out_valid cycle.
        wait_idle();
        in_valid = 1'b1;
        bin_in   = 16'd4321;
        @(posedge clk); #1;
        bin_in = 16'd1111;
        p = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
        for (int e = 0; e < 60; e++) begin
            if (out_valid_u) begin
                if (p == 0) begin
                    t0 = e; r0 = bcd_u; bin_in = 16'd9999;
                end else begin
                    t1 = e; r1 = bcd_u;
                end
                p++;
            end else if (p == 1 && in_valid) begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        $display("b2b: pulses=%0d r0=%h r1=%h gap=%0d", p, r0, r1, t1 - t0);
        check("b2b_pulses", 32'(p), 32'd2);
        check("b2b_first", 32'(r0), 32'h04321);
        check("b2b_second", 32'(r1), 32'h09999);
        check("b2b_gap", 32'(t1 - t0), 32'(W + 2));

        // Reset during SHIFT after six iterations; the seventh edge sees rst.
        wait_idle();
        in_valid = 1'b1;
        bin_in   = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-shift reset: in_ready=%0b out_valid=%0b bcd=%h", in_ready_u, out_valid_u, bcd_u);
        check("mrst_in_ready", {31'd0, in_ready_u}, 32'd1);
        check("mrst_out_valid", {31'd0, out_valid_u}, 32'd0);
        check("mrst_bcd", 32'(bcd_u), 32'd0);
        check("mrst_neg", {31'd0, neg_s}, 32'd0);
        p = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (out_valid_u || out_valid_s) p++;
        end
        check("mrst_no_stale", 32'(p), 32'd0);

        // Random samples against a decimal reference.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0]   v;
            logic [4*D-1:0] eu, es;
            logic           en;
            bit             digits_ok;
            v  = W'($urandom);
            eu = to_bcd(32'(v));
            en = v[W-1];
            es = en ? to_bcd(32'(17'h10000 - 17'(v))) : to_bcd(32'(v));
            convert(v, bu, bs, ns);
            $display("rnd %0d: bin=%h u=%h s=%h neg=%0b", i, v, bu, bs, ns);
            check("rnd_u_bcd", 32'(bu), 32'(eu));
            check("rnd_s_bcd", 32'(bs), 32'(es));
            check("rnd_s_neg", {31'd0, ns}, {31'd0, en});
            digits_ok = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (bu[4*k +: 4] > 4'd9 || bs[4*k +: 4] > 4'd9) digits_ok = 1'b0;
            end
            check("rnd_digits", {31'd0, digits_ok}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
